pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction-fetch stage of the PMIPSL0 multi-cycle pipeline: holds the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register that feeds the 4-bit opcode to the controller. It obeys the controller's PCControl encoding (Stall/Inc/CondLoad). It accepts the jump and branch redirects produced by the memory-access stage. It also keeps sticky fault flags and a fetch counter for debug.

## Interface
- PC_WIDTH, 16: width of PC, addresses and targets
- INSTR_WIDTH, 16: instruction width; opcode is the top 4 bits
- RESET_PC, 0: PC value after reset; must be even
- PC_STEP, 2: increment applied on Inc

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset; low clears all state immediately
- PCControl  in  2  from controller: 0 Stall, 1 Inc, 2 CondLoad, 3 reserved
- JumpTaken  in  1  from EX/MEM: jump instruction in memory stage
- BranchTaken  in  1  from EX/MEM: Branch AND ALUzero
- JumpAddr  in  PC_WIDTH  jump target from EX/MEM
- BranchTarget  in  PC_WIDTH  branch target from EX/MEM
- IMemData  in  INSTR_WIDTH  instruction memory read data (asynchronous read of IMemAddr)
- IMemAddr  out  PC_WIDTH  current PC, driven directly from the PC register
- IFID_Instr  out  INSTR_WIDTH  registered instruction
- IFID_PCPlus2  out  PC_WIDTH  registered PC+PC_STEP of that instruction, for branch target adder
- OpCode  out  4  IFID_Instr[INSTR_WIDTH-1 -: 4], to controller
- FetchCount  out  16  number of Inc cycles since reset, saturating
- MisalignFault  out  1  sticky: an odd target was loaded
- CtrlFault  out  1  sticky: PCControl==3 seen

## Operation
- Reset (reset low, async): PC=RESET_PC, IFID_Instr=0, IFID_PCPlus2=0, FetchCount=0, both faults=0. Outputs are valid in the same cycle, with no clock needed.
- Inc (1): PC<=PC+PC_STEP, modulo 2^PC_WIDTH, so 0xFFFE wraps to 0x0000.
  - On the same edge, IFID_Instr<=IMemData and IFID_PCPlus2<=PC+PC_STEP, both taken from the pre-edge PC.
  - FetchCount<=FetchCount+1, saturating at 0xFFFF.
- Stall (0): PC, IF/ID, FetchCount all hold.
- CondLoad (2):
  - If JumpTaken: PC<=JumpAddr.
  - Else if BranchTaken: PC<=BranchTarget.
  - Else PC holds.
  - Jump has priority when both are high.
  - IF/ID and FetchCount hold.
  - JumpTaken/BranchTaken are ignored in every other PCControl code.
- Misaligned target: if the selected target has bit0=1, load it with bit0 cleared and set MisalignFault. The flag is sticky until reset. A misaligned target that is not selected (e.g. BranchTarget while JumpTaken is high) does not set the flag.
- Reserved (3): treated as Stall; sets CtrlFault, sticky until reset.
- No other state is kept. Under the controller's 0,1,2,3 sequence, one instruction is fetched per 4 cycles and a redirect takes effect on the Inc that follows.

## Timing
- IMemAddr is combinational from the PC register only, with no input-to-output paths. IMemData must settle within the same cycle.
- Latency:
  - Inc: IFID_Instr and OpCode are valid 1 cycle after the Inc edge. This is what the controller decodes in state 1.
  - CondLoad: the new PC appears on IMemAddr immediately after the CondLoad edge. It is fetched on the next Inc edge.
- Reset asserted mid-operation, in any state, clears everything asynchronously. Deassertion is taken synchronously by the first rising edge with reset high. That edge performs the operation given by PCControl.
- All registered outputs change only on the rising clock edge or on reset assertion.

## Test plan
- Reset then 4x Inc with IMemData=0x3123,0x5000,0x6111,0x0000: IMemAddr goes 0,2,4,6,8. IFID_Instr tracks each word one edge later, and IFID_PCPlus2=2,4,6,8. OpCode=3,5,6,0. FetchCount=4.
- Full controller sequence (1,0,0,2) with BranchTaken=1, BranchTarget=0x0040: after the CondLoad edge PC=0x0040. With BranchTaken=0, PC stays at 0x0002.
- CondLoad with JumpTaken=1, JumpAddr=0x0100, BranchTaken=1, BranchTarget=0x0200: PC=0x0100, MisalignFault=0. Repeat with JumpAddr=0x0101: PC=0x0100, MisalignFault=1 and it stays 1 through further cycles.
- PC=0xFFFE then Inc: PC=0x0000 and IFID_PCPlus2=0x0000. PCControl=3 for one cycle: PC and IF/ID unchanged, CtrlFault=1.
- Force FetchCount to 0xFFFF via 65535 Inc cycles, then Inc again: FetchCount holds at 0xFFFF.
- Assert reset low between clock edges mid-sequence (PC=0x0040): PC, IF/ID, FetchCount and faults clear before the next edge. Release reset with PCControl=1: first edge gives PC=0x0002.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch stage of the PMIPSL0 multi-cycle pipeline. It holds the
// program counter, drives the instruction-memory address and loads the IF/ID
// pipeline register that supplies the 4-bit opcode to the controller.
//
// The controller steps this unit through PCControl:
//   0 Stall    : everything holds
//   1 Inc      : PC += PC_STEP, IF/ID captures IMemData and PC+PC_STEP,
//                FetchCount increments (saturating)
//   2 CondLoad : PC loads JumpAddr (priority) or BranchTarget when the
//                matching *Taken flag is high, otherwise holds
//   3 reserved : behaves as Stall and sets the sticky CtrlFault flag
//
// There is no valid/ready handshake. PCControl is the only qualifier, and
// every output is a plain register or a decode of one.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   PCControl     in   2-bit controller command (see above)
//   JumpTaken     in   jump instruction in the memory stage
//   BranchTaken   in   branch condition satisfied in the memory stage
//   JumpAddr      in   jump target
//   BranchTarget  in   branch target
//   IMemData      in   instruction word read asynchronously at IMemAddr
//   IMemAddr      out  current PC, straight from the PC register
//   IFID_Instr    out  registered instruction
//   IFID_PCPlus2  out  registered PC+PC_STEP of that instruction
//   OpCode        out  top 4 bits of IFID_Instr
//   FetchCount    out  Inc cycles since reset, saturating at 0xFFFF
//   MisalignFault out  sticky: an odd target was selected and loaded
//   CtrlFault     out  sticky: reserved PCControl code seen
//
// RESET_PC is expected to be even.
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 16,
  parameter int unsigned         INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned         PC_STEP     = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             PCControl,
  input  logic                   JumpTaken,
  input  logic                   BranchTaken,
  input  logic [PC_WIDTH-1:0]    JumpAddr,
  input  logic [PC_WIDTH-1:0]    BranchTarget,
  input  logic [INSTR_WIDTH-1:0] IMemData,
  output logic [PC_WIDTH-1:0]    IMemAddr,
  output logic [INSTR_WIDTH-1:0] IFID_Instr,
  output logic [PC_WIDTH-1:0]    IFID_PCPlus2,
  output logic [3:0]             OpCode,
  output logic [15:0]            FetchCount,
  output logic                   MisalignFault,
  output logic                   CtrlFault
);

  typedef enum logic [1:0] {
    CTRL_STALL = 2'd0,
    CTRL_INC   = 2'd1,
    CTRL_LOAD  = 2'd2,
    CTRL_RSVD  = 2'd3
  } pc_ctrl_e;

  localparam logic [PC_WIDTH-1:0] STEP    = PC_WIDTH'(PC_STEP);
  localparam logic [15:0]         CNT_MAX = 16'hFFFF;

  // State registers and their next-state values
  logic [PC_WIDTH-1:0]    pc_q,       pc_d;
  logic [INSTR_WIDTH-1:0] instr_q,    instr_d;
  logic [PC_WIDTH-1:0]    pc_plus_q,  pc_plus_d;
  logic [15:0]            fcount_q,   fcount_d;
  logic                   misalign_q, misalign_d;
  logic                   ctrl_flt_q, ctrl_flt_d;

  // Combinational helpers
  pc_ctrl_e               ctrl;
  logic [PC_WIDTH-1:0]    pc_next_seq;
  logic                   load_sel;
  logic [PC_WIDTH-1:0]    load_target;

  assign ctrl        = pc_ctrl_e'(PCControl);
  // Modulo 2^PC_WIDTH: 0xFFFE + 2 wraps to 0x0000 by truncation.
  assign pc_next_seq = pc_q + STEP;

  // Redirect selection. Jump wins over branch; an unselected target (even an
  // odd one) never reaches the PC or the fault flag.
  always_comb begin
    load_sel    = 1'b0;
    load_target = pc_q;
    if (JumpTaken) begin
      load_sel    = 1'b1;
      load_target = JumpAddr;
    end else if (BranchTaken) begin
      load_sel    = 1'b1;
      load_target = BranchTarget;
    end
  end

  // Next-state logic
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus_d  = pc_plus_q;
    fcount_d   = fcount_q;
    misalign_d = misalign_q;
    ctrl_flt_d = ctrl_flt_q;

    case (ctrl)
      CTRL_INC: begin
        // IF/ID captures the word at the pre-edge PC together with the
        // sequential address that the branch-target adder needs downstream.
        pc_d      = pc_next_seq;
        instr_d   = IMemData;
        pc_plus_d = pc_next_seq;
        if (fcount_q != CNT_MAX) begin
          fcount_d = fcount_q + 16'd1;
        end
      end
      CTRL_LOAD: begin
        if (load_sel) begin
          // Instructions are halfword aligned; an odd target is forced even
          // and the event is recorded rather than trapped.
          pc_d = {load_target[PC_WIDTH-1:1], 1'b0};
          if (load_target[0]) begin
            misalign_d = 1'b1;
          end
        end
      end
      CTRL_RSVD: begin
        ctrl_flt_d = 1'b1;
      end
      default: begin
        // Stall: hold everything
      end
    endcase
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc_plus_q  <= '0;
      fcount_q   <= '0;
      misalign_q <= 1'b0;
      ctrl_flt_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus_q  <= pc_plus_d;
      fcount_q   <= fcount_d;
      misalign_q <= misalign_d;
      ctrl_flt_q <= ctrl_flt_d;
    end
  end

  // Outputs come straight from registers; no input-to-output paths.
  assign IMemAddr      = pc_q;
  assign IFID_Instr    = instr_q;
  assign IFID_PCPlus2  = pc_plus_q;
  assign OpCode        = instr_q[INSTR_WIDTH-1 -: 4];
  assign FetchCount    = fcount_q;
  assign MisalignFault = misalign_q;
  assign CtrlFault     = ctrl_flt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Self-checking bench for pc_fetch_unit. A driver issues one PCControl
// command per cycle, advances a reference model of the fetch stage and pushes
// the expected post-edge outputs into exp_q. A monitor pops one entry after
// every rising edge and compares it with the DUT. Reset behaviour and the
// directed scenarios are additionally checked against constants.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam int EXP_W = 16 + 16 + 16 + 16 + 1 + 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic [1:0]  PCControl    = 2'd0;
  logic        JumpTaken    = 1'b0;
  logic        BranchTaken  = 1'b0;
  logic [15:0] JumpAddr     = 16'h0000;
  logic [15:0] BranchTarget = 16'h0000;
  logic [15:0] IMemData;
  logic [15:0] IMemAddr;
  logic [15:0] IFID_Instr;
  logic [15:0] IFID_PCPlus2;
  logic [3:0]  OpCode;
  logic [15:0] FetchCount;
  logic        MisalignFault;
  logic        CtrlFault;

  pc_fetch_unit #(
    .PC_WIDTH    (16),
    .INSTR_WIDTH (16),
    .RESET_PC    (16'h0000),
    .PC_STEP     (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .PCControl     (PCControl),
    .JumpTaken     (JumpTaken),
    .BranchTaken   (BranchTaken),
    .JumpAddr      (JumpAddr),
    .BranchTarget  (BranchTarget),
    .IMemData      (IMemData),
    .IMemAddr      (IMemAddr),
    .IFID_Instr    (IFID_Instr),
    .IFID_PCPlus2  (IFID_PCPlus2),
    .OpCode        (OpCode),
    .FetchCount    (FetchCount),
    .MisalignFault (MisalignFault),
    .CtrlFault     (CtrlFault)
  );

  // Instruction memory: asynchronous read, 256 halfwords mirrored over the
  // address space.
  logic [15:0] imem [0:255];
  assign IMemData = imem[IMemAddr[8:1]];

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q [$];
  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_pc, m_instr, m_pp2, m_cnt;
  logic        m_mis, m_ctl;

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
    m_cnt = 16'h0000; m_mis = 1'b0; m_ctl = 1'b0;
  endtask

  // One clock edge of the fetch stage, straight from the command semantics.
  task automatic model_step(input logic [1:0] c, input logic jt, input logic bt,
                            input logic [15:0] ja, input logic [15:0] bta);
    logic [15:0] tgt;
    if (c == 2'd1) begin
      m_instr = imem[m_pc[8:1]];
      m_pp2   = m_pc + 16'd2;
      m_pc    = m_pc + 16'd2;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (c == 2'd2 && (jt || bt)) begin
      tgt = jt ? ja : bta;
      if (tgt % 2 == 1) m_mis = 1'b1;
      m_pc = tgt - (tgt % 2);
    end else if (c == 2'd3) begin
      m_ctl = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [1:0] c, input logic jt = 1'b0, input logic bt = 1'b0,
                       input logic [15:0] ja = 16'h0, input logic [15:0] bta = 16'h0);
    @(negedge clock);
    PCControl = c; JumpTaken = jt; BranchTaken = bt; JumpAddr = ja; BranchTarget = bta;
    model_step(c, jt, bt, ja, bta);
    exp_q.push_back({m_pc, m_instr, m_pp2, m_cnt, m_mis, m_ctl});
    @(posedge clock);
    #2;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_pc"},    IMemAddr, 16'h0000);
    chk({tag, "_instr"}, IFID_Instr, 16'h0000);
    chk({tag, "_pp2"},   IFID_PCPlus2, 16'h0000);
    chk({tag, "_cnt"},   FetchCount, 16'h0000);
    chk({tag, "_op"},    {12'h0, OpCode}, 16'h0000);
    chk({tag, "_mis"},   {15'h0, MisalignFault}, 16'h0000);
    chk({tag, "_ctl"},   {15'h0, CtrlFault}, 16'h0000);
  endtask

  // Reset pulse between edges; released with a Stall so no edge is expected.
  task automatic hard_reset();
    @(negedge clock);
    PCControl = 2'd0; JumpTaken = 1'b0; BranchTaken = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    reset = 1'b1;
    @(posedge clock);
    #2;
  endtask

  // Reset asserted mid-cycle, checked before any edge, released with Inc.
  task automatic reset_mid(input string tag);
    @(negedge clock);
    #1;
    PCControl = 2'd1; JumpTaken = 1'b0; BranchTaken = 1'b0;
    reset = 1'b0;
    #1;
    check_cleared(tag);
    model_reset();
    #1;
    reset = 1'b1;
    model_step(2'd1, 1'b0, 1'b0, 16'h0, 16'h0);
    exp_q.push_back({m_pc, m_instr, m_pp2, m_cnt, m_mis, m_ctl});
    @(posedge clock);
    #2;
    chk({tag, "_release_pc"}, IMemAddr, 16'h0002);
  endtask

  // ---------------- monitor ----------------
  logic [EXP_W-1:0] mon_e;
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pc",    IMemAddr,     mon_e[65:50]);
      chk("instr", IFID_Instr,   mon_e[49:34]);
      chk("pp2",   IFID_PCPlus2, mon_e[33:18]);
      chk("op",    {12'h0, OpCode}, {12'h0, mon_e[49:46]});
      chk("cnt",   FetchCount,   mon_e[17:2]);
      chk("mis",   {15'h0, MisalignFault}, {15'h0, mon_e[1]});
      chk("ctl",   {15'h0, CtrlFault},     {15'h0, mon_e[0]});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'($urandom_range(0, 65535));
    imem[0] = 16'h3123; imem[1] = 16'h5000; imem[2] = 16'h6111; imem[3] = 16'h0000;
    model_reset();

    // Reset at time zero: outputs valid with no clock edge yet.
    #1;
    check_cleared("por");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #2;

    // Four sequential fetches.
    cycle(2'd1); chk("seq_op0", {12'h0, OpCode}, 16'h0003);
    cycle(2'd1); chk("seq_op1", {12'h0, OpCode}, 16'h0005);
    cycle(2'd1); chk("seq_op2", {12'h0, OpCode}, 16'h0006);
    cycle(2'd1); chk("seq_op3", {12'h0, OpCode}, 16'h0000);
    chk("seq_pc",  IMemAddr, 16'h0008);
    chk("seq_pp2", IFID_PCPlus2, 16'h0008);
    chk("seq_cnt", FetchCount, 16'h0004);

    // Controller sequence with a taken and a not-taken branch.
    hard_reset();
    cycle(2'd1); cycle(2'd0); cycle(2'd0); cycle(2'd2, 1'b0, 1'b1, 16'h0, 16'h0040);
    chk("br_taken_pc", IMemAddr, 16'h0040);
    hard_reset();
    cycle(2'd1); cycle(2'd0); cycle(2'd0); cycle(2'd2, 1'b0, 1'b0, 16'h0, 16'h0040);
    chk("br_nt_pc", IMemAddr, 16'h0002);

    // Jump priority; unselected odd branch target must not flag.
    cycle(2'd2, 1'b1, 1'b1, 16'h0100, 16'h0201);
    chk("jmp_pc", IMemAddr, 16'h0100);
    chk("jmp_mis", {15'h0, MisalignFault}, 16'h0000);
    // Redirect flags ignored outside CondLoad.
    cycle(2'd0, 1'b1, 1'b1, 16'h0300, 16'h0400);
    chk("ign_pc", IMemAddr, 16'h0100);
    cycle(2'd2, 1'b1, 1'b0, 16'h0101, 16'h0);
    chk("mis_pc", IMemAddr, 16'h0100);
    chk("mis_set", {15'h0, MisalignFault}, 16'h0001);
    cycle(2'd1); cycle(2'd0);
    chk("mis_sticky", {15'h0, MisalignFault}, 16'h0001);

    // Wrap at the top of the address space, then a reserved command.
    hard_reset();
    cycle(2'd2, 1'b1, 1'b0, 16'hFFFE, 16'h0);
    cycle(2'd1);
    chk("wrap_pc",  IMemAddr, 16'h0000);
    chk("wrap_pp2", IFID_PCPlus2, 16'h0000);
    cycle(2'd3);
    chk("rsvd_pc",  IMemAddr, 16'h0000);
    chk("rsvd_ctl", {15'h0, CtrlFault}, 16'h0001);

    // Reset mid-operation with PC at 0x0040.
    hard_reset();
    cycle(2'd2, 1'b0, 1'b1, 16'h0, 16'h0040);
    chk("pre_mid_pc", IMemAddr, 16'h0040);
    reset_mid("mid");

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      logic [1:0]  c;
      logic [15:0] ja, bta;
      c   = (($urandom_range(0, 19)) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ja  = 16'($urandom_range(0, 65535));
      bta = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0) begin ja[0] = 1'b0; bta[0] = 1'b0; end
      cycle(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ja, bta);
      if (n == 1000) reset_mid("rnd_mid");
    end

    // Fetch counter saturation.
    hard_reset();
    for (int n = 0; n < 65535; n++) cycle(2'd1);
    chk("cnt_max", FetchCount, 16'hFFFF);
    cycle(2'd1);
    chk("cnt_sat", FetchCount, 16'hFFFF);

    // Drain the scoreboard with a bounded wait.
    for (int n = 0; n < 4 && exp_q.size() > 0; n++) @(posedge clock);
    #2;
    chk("drain", 16'(exp_q.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
